// File: rtl/matr_mac_seq_nxn.sv
// NxN matrix multiply Res = A x B on one time-shared MAC; N^3 RUN cycles, done one cycle later.
// No backpressure: start is only taken in IDLE, and Res holds the last result until the next run writes it.
module matr_mac_seq_nxn #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8,
    parameter int SIGNED = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    sat_en,
    input  logic [N*N*DATA_W-1:0]   A,
    input  logic [N*N*DATA_W-1:0]   B,
    output logic                    busy,
    output logic                    done,
    output logic [N*N*OUT_W-1:0]    Res
);

    localparam int IW = $clog2(N);
    localparam int AW = 2*DATA_W + $clog2(N) + 1;
    localparam int CW = ((AW > OUT_W) ? AW : OUT_W) + 1;

    // Clamp bounds held one bit wider than both acc and Res so a signed compare covers both modes.
    localparam logic signed [CW-1:0] MAXV = (SIGNED != 0) ?
        CW'((CW'(1) << (OUT_W-1)) - CW'(1)) : CW'((CW'(1) << OUT_W) - CW'(1));
    localparam logic signed [CW-1:0] MINV = (SIGNED != 0) ? ~MAXV : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_r   [N][N];
    logic [DATA_W-1:0]   b_r   [N][N];
    logic [OUT_W-1:0]    res_r [N][N];
    logic                sat_r;
    logic [IW-1:0]       i_r;
    logic [IW-1:0]       j_r;
    logic [IW-1:0]       k_r;
    logic [AW-1:0]       acc;

    logic [AW-1:0]          op_a;
    logic [AW-1:0]          op_b;
    logic [AW-1:0]          prod;
    logic [AW-1:0]          acc_sum;
    logic signed [CW-1:0]   sum_ext;
    logic [OUT_W-1:0]       res_val;

    // Operands are extended to the full acc width, so the low AW bits of the product are exact.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (SIGNED != 0) begin
            op_a = AW'($signed(a_r[i_r][k_r]));
            op_b = AW'($signed(b_r[k_r][j_r]));
        end else begin
            op_a = AW'(a_r[i_r][k_r]);
            op_b = AW'(b_r[k_r][j_r]);
        end
        prod    = op_a * op_b;
        acc_sum = acc + prod;
        if (SIGNED != 0) begin
            sum_ext = CW'($signed(acc_sum));
        end else begin
            sum_ext = CW'(acc_sum);
        end
        if (sat_r && (sum_ext > MAXV)) begin
            res_val = MAXV[OUT_W-1:0];
        end else if (sat_r && (sum_ext < MINV)) begin
            res_val = MINV[OUT_W-1:0];
        end else begin
            res_val = sum_ext[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sat_r <= 1'b0;
            i_r   <= '0;
            j_r   <= '0;
            k_r   <= '0;
            acc   <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_r[r][c]   <= '0;
                    b_r[r][c]   <= '0;
                    res_r[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        for (int r = 0; r < N; r++) begin
                            for (int c = 0; c < N; c++) begin
                                a_r[r][c] <= A[(N*N-1-(r*N+c))*DATA_W +: DATA_W];
                                b_r[r][c] <= B[(N*N-1-(r*N+c))*DATA_W +: DATA_W];
                            end
                        end
                        sat_r <= sat_en;
                        i_r   <= '0;
                        j_r   <= '0;
                        k_r   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (k_r == IW'(N-1)) begin
                        res_r[i_r][j_r] <= res_val;
                        acc <= '0;
                        k_r <= '0;
                        if (j_r == IW'(N-1)) begin
                            j_r <= '0;
                            if (i_r == IW'(N-1)) begin
                                i_r   <= '0;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_DONE;
                            end else begin
                                i_r <= i_r + 1'b1;
                            end
                        end else begin
                            j_r <= j_r + 1'b1;
                        end
                    end else begin
                        acc <= acc_sum;
                        k_r <= k_r + 1'b1;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar c = 0; c < N; c++) begin : g_col
            assign Res[(N*N-1-(r*N+c))*OUT_W +: OUT_W] = res_r[r][c];
        end
    end

endmodule

// File: tb/tb_matr_mac_seq_nxn.sv
// Bench for matr_mac_seq_nxn: N=2 unsigned, N=2 signed and N=3 wide-output instances against a matrix model.
module tb_matr_mac_seq_nxn;

    logic clk = 1'b0;
    logic reset;

    logic         start2, sat2, busy2, done2;
    logic [31:0]  A2, B2, Res2;
    logic         starts, sats, busys, dones;
    logic [31:0]  As, Bs, Ress;
    logic         start3, sat3, busy3, done3;
    logic [71:0]  A3, B3;
    logic [143:0] Res3;

    int n_checks = 0;
    int n_pass   = 0;
    logic [143:0] e2, es, e3;

    always #5 clk = ~clk;

    matr_mac_seq_nxn #(.N(2), .DATA_W(8), .OUT_W(8), .SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .start(start2), .sat_en(sat2), .A(A2), .B(B2),
        .busy(busy2), .done(done2), .Res(Res2));

    matr_mac_seq_nxn #(.N(2), .DATA_W(8), .OUT_W(8), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .start(starts), .sat_en(sats), .A(As), .B(Bs),
        .busy(busys), .done(dones), .Res(Ress));

    matr_mac_seq_nxn #(.N(3), .DATA_W(8), .OUT_W(16), .SIGNED(0)) u_n3 (
        .clk(clk), .reset(reset), .start(start3), .sat_en(sat3), .A(A3), .B(B3),
        .busy(busy3), .done(done3), .Res(Res3));

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int nof(input int w);
        return (w == 2) ? 3 : 2;
    endfunction

    // Plain matrix product with optional clamp, packed row-major with element 0 in the MSBs.
    function automatic logic [143:0] model(input int n, input int ow, input bit sgn, input bit sat,
                                           input int a[9], input int b[9]);
        logic [143:0] r;
        longint s, lo, hi, mask;
        r    = '0;
        mask = (longint'(1) << ow) - 1;
        lo   = sgn ? -(longint'(1) << (ow-1)) : 0;
        hi   = sgn ? (longint'(1) << (ow-1)) - 1 : mask;
        for (int idx = 0; idx < n*n; idx++) begin
            s = 0;
            for (int k = 0; k < n; k++)
                s += longint'(a[(idx/n)*n+k]) * longint'(b[k*n+(idx%n)]);
            if (sat) begin
                if (s > hi) s = hi;
                else if (s < lo) s = lo;
            end
            r = r | (144'(s & mask) << ((n*n-1-idx)*ow));
        end
        return r;
    endfunction

    function automatic logic [71:0] pack(input int n, input int a[9]);
        logic [71:0] r;
        r = '0;
        for (int idx = 0; idx < n*n; idx++) r[(n*n-1-idx)*8 +: 8] = 8'(a[idx]);
        return r;
    endfunction

    task automatic drive(input int w, input int a[9], input int b[9], input bit s);
        logic [71:0] pa, pb;
        pa = pack(nof(w), a);
        pb = pack(nof(w), b);
        case (w)
            0:       begin A2 = pa[31:0]; B2 = pb[31:0]; sat2 = s; end
            1:       begin As = pa[31:0]; Bs = pb[31:0]; sats = s; end
            default: begin A3 = pa;       B3 = pb;       sat3 = s; end
        endcase
    endtask

    task automatic set_start(input int w, input bit v);
        case (w)
            0:       start2 = v;
            1:       starts = v;
            default: start3 = v;
        endcase
    endtask

    task automatic set_exp(input int w, input int a[9], input int b[9], input bit s);
        case (w)
            0:       e2 = model(2, 8, 1'b0, s, a, b);
            1:       es = model(2, 8, 1'b1, s, a, b);
            default: e3 = model(3, 16, 1'b0, s, a, b);
        endcase
    endtask

    function automatic bit get_busy(input int w);
        return (w == 0) ? busy2 : (w == 1) ? busys : busy3;
    endfunction

    function automatic bit get_done(input int w);
        return (w == 0) ? done2 : (w == 1) ? dones : done3;
    endfunction

    task automatic rnd(input int w, output int a[9], output int b[9]);
        for (int i = 0; i < 9; i++) begin
            a[i] = int'($urandom_range(0, 255));
            b[i] = int'($urandom_range(0, 255));
            if (w == 1) begin
                a[i] -= 128;
                b[i] -= 128;
            end
        end
    endtask

    // One full run; lat is the cycle (counting the cycle after the start edge as 1) in which done shows.
    task automatic run(input int w, input int a[9], input int b[9], input bit s, output int lat);
        int nn, busyc;
        nn = nof(w) * nof(w) * nof(w);
        @(negedge clk);
        drive(w, a, b, s);
        set_exp(w, a, b, s);
        set_start(w, 1'b1);
        @(posedge clk); #1;
        set_start(w, 1'b0);
        busyc = get_busy(w) ? 1 : 0;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (get_done(w)) begin
                lat = c + 1;
                break;
            end
            if (get_busy(w)) busyc++;
        end
        chk("latency", 144'(lat), 144'(nn + 1));
        chk("busy_cycles", 144'(busyc), 144'(nn));
        @(posedge clk); #1;
        chk("done_pulse", 144'(get_done(w)), 144'(0));
    endtask

    initial begin
        int ta[9], tb[9], ta2[9], tb2[9], lat;
        bit bh;
        reset = 1'b0;
        {start2, sat2, A2, B2} = '0;
        {starts, sats, As, Bs} = '0;
        {start3, sat3, A3, B3} = '0;
        e2 = '0; es = '0; e3 = '0;

        fork
            forever begin
                @(negedge clk);
                if (reset) begin
                    if (done2) chk("cmp_n2_unsigned", 144'(Res2), e2);
                    if (dones) chk("cmp_n2_signed", 144'(Ress), es);
                    if (done3) chk("cmp_n3", Res3, e3);
                end
            end
        join_none

        #1;
        chk("rst_res2", 144'(Res2), 144'(0));
        chk("rst_busy2", 144'(busy2), 144'(0));
        chk("rst_done2", 144'(done2), 144'(0));
        chk("rst_res3", Res3, 144'(0));
        @(negedge clk);
        reset = 1'b1;

        ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        chk("pin_model_t1", model(2, 8, 1'b0, 1'b0, ta, tb), 144'h13162B32);
        run(0, ta, tb, 1'b0, lat);
        chk("t1_res", 144'(Res2), 144'h13162B32);
        chk("t1_done_cycle", 144'(lat), 144'(9));

        ta = '{200, 200, 200, 200, 0, 0, 0, 0, 0};
        tb = '{2, 2, 2, 2, 0, 0, 0, 0, 0};
        chk("pin_model_wrap", model(2, 8, 1'b0, 1'b0, ta, tb), 144'h20202020);
        run(0, ta, tb, 1'b0, lat);
        chk("t2_wrap", 144'(Res2), 144'h20202020);
        run(0, ta, tb, 1'b1, lat);
        chk("t2_sat", 144'(Res2), 144'hFFFFFFFF);

        ta = '{-1, 2, 3, -4, 0, 0, 0, 0, 0};
        tb = '{5, -6, 7, 8, 0, 0, 0, 0, 0};
        chk("pin_model_signed", model(2, 8, 1'b1, 1'b0, ta, tb), 144'h0916F3CE);
        run(1, ta, tb, 1'b0, lat);
        chk("t3_signed", 144'(Ress), 144'h0916F3CE);
        ta = '{-128, -128, -128, -128, 0, 0, 0, 0, 0};
        tb = '{127, 127, 127, 127, 0, 0, 0, 0, 0};
        run(1, ta, tb, 1'b1, lat);
        chk("t3_signed_sat", 144'(Ress), 144'h80808080);
        run(1, ta, tb, 1'b0, lat);
        chk("t3_signed_wrap", 144'(Ress), 144'h00000000);

        // Start held throughout, operands scrambled every cycle after capture.
        rnd(0, ta, tb);
        @(negedge clk);
        drive(0, ta, tb, 1'b0);
        set_exp(0, ta, tb, 1'b0);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        bh = busy2;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            rnd(0, ta2, tb2);
            drive(0, ta2, tb2, 1'b1);
            @(posedge clk); #1;
            if (c < 8) bh = bh & busy2;
        end
        chk("t4_busy_held", 144'(bh), 144'(1));
        chk("t4_done", 144'(done2), 144'(1));
        @(negedge clk);
        rnd(0, ta, tb);
        drive(0, ta, tb, 1'b0);
        @(posedge clk); #1;
        chk("t4_start_in_done_ignored", 144'(busy2), 144'(0));
        chk("t4_done_dropped", 144'(done2), 144'(0));
        @(negedge clk);
        set_exp(0, ta, tb, 1'b0);
        @(posedge clk); #1;
        chk("t4_relaunch_busy", 144'(busy2), 144'(1));
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            set_start(0, 1'b0);
            rnd(0, ta2, tb2);
            drive(0, ta2, tb2, 1'b1);
            @(posedge clk); #1;
            if (done2) break;
        end
        chk("t4_second_done", 144'(done2), 144'(1));
        @(posedge clk); #1;

        // Asynchronous reset in the middle of a run.
        ta = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
        tb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
        @(negedge clk);
        drive(0, ta, tb, 1'b0);
        set_exp(0, ta, tb, 1'b0);
        set_start(0, 1'b1);
        @(posedge clk); #1;
        set_start(0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("t5_res_cleared", 144'(Res2), 144'(0));
        chk("t5_busy_cleared", 144'(busy2), 144'(0));
        chk("t5_done_cleared", 144'(done2), 144'(0));
        @(posedge clk); #1;
        chk("t5_stays_idle", 144'(busy2), 144'(0));
        @(negedge clk);
        reset = 1'b1;
        run(0, ta, tb, 1'b0, lat);
        chk("t5_rerun_res", 144'(Res2), 144'h13162B32);

        ta = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        tb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
        run(2, ta, tb, 1'b0, lat);
        chk("t6_identity", Res3, 144'h0001_0002_0003_0004_0005_0006_0007_0008_0009);
        chk("t6_done_cycle", 144'(lat), 144'(28));

        for (int it = 0; it < 15; it++) begin
            rnd(it % 3, ta, tb);
            run(it % 3, ta, tb, 1'($urandom_range(0, 1)), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
